mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: none; opcode/funct/alu_op encodings fixed per REQ-016..REQ-018.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-004 run  input  1  level; 1 = keep issuing instructions.
REQ-005 imem_ack  input  1  instruction memory data valid, sampled only in FETCH.
REQ-006 imem_data  input  32  instruction word; opcode=[31:26], funct=[5:0].
REQ-007 imem_req  output  1  fetch request, held until acknowledged.
REQ-008 pc_en  output  1  one-cycle PC advance strobe.
REQ-009 alu_op  output  3  ALU operation select.
REQ-010 rd_src  output  1  1 = destination rt (I-type), 0 = rd (R-type).
REQ-011 alu_src2  output  1  1 = ALU operand B is sign/zero-extended immediate.
REQ-012 writeenable  output  1  register-file write strobe.
REQ-013 except  output  1  sticky illegal-instruction flag.
REQ-014 busy  output  1  1 in any state other than IDLE and EXCEPT.
REQ-015 retired  output  16  count of completed instructions.

Function
REQ-016 Legal R-type: opcode 6'h00 with funct ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27; any other funct under opcode 6'h00 is illegal.
REQ-017 Legal I-type: ADDI 6'h08, ANDI 6'h0c, ORI 6'h0d, XORI 6'h0e; every other opcode is illegal.
REQ-018 alu_op: add 3'b010, sub 3'b011, and 3'b100, or 3'b101, nor 3'b110, xor 3'b111; ADDI->add, ANDI->and, ORI->or, XORI->xor.
REQ-019 States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, EXCEPT; state register updates only on rising clock or reset.
REQ-020 IDLE: run=1 -> FETCH next cycle; run=0 -> stay.
REQ-021 FETCH: imem_req=1 every cycle; imem_ack=0 -> stay; imem_ack=1 -> capture imem_data into internal IR, go DECODE.
REQ-022 DECODE: classify IR; legal -> register alu_op/rd_src/alu_src2, go EXECUTE; illegal -> go EXCEPT.
REQ-023 EXECUTE: one cycle, control outputs valid, writeenable=0, go WRITEBACK.
REQ-024 WRITEBACK: writeenable=1 and pc_en=1 for exactly this cycle; retired increments by 1; run=1 -> FETCH, run=0 -> IDLE.
REQ-025 alu_op/rd_src/alu_src2 hold their registered values from EXECUTE entry until next DECODE exit; outside that window they keep the last value.
REQ-026 EXCEPT: except=1, imem_req=0, writeenable=0, pc_en=0, retired frozen; exit only via reset; run and imem_ack ignored.
REQ-027 Latency: imem_ack sampled high at edge N -> writeenable high during cycle after edge N+2 (DECODE, EXECUTE, WRITEBACK).
REQ-028 Back-to-back: run held 1 -> imem_req reasserts the cycle after WRITEBACK; minimum 4 cycles per instruction.
REQ-029 retired wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-030 imem_ack outside FETCH has no effect; imem_data outside the ack cycle is ignored.
REQ-031 run deasserted mid-instruction does not abort it; the instruction completes and the FSM then returns to IDLE.
REQ-032 Illegal instruction: no writeenable, no pc_en, retired not incremented.

Reset
REQ-033 reset=1 at any time, including mid-FETCH or in EXCEPT, forces IDLE immediately without waiting for a clock edge.
REQ-034 While reset=1 all outputs are 0: imem_req, pc_en, writeenable, except, busy, rd_src, alu_src2, alu_op=3'b000, retired=16'h0000.
REQ-035 First FETCH after reset release requires run=1 at a rising edge.

Verification
REQ-036 run=1, ack 2 cycles after req with 32'h00221820 (ADD) -> alu_op=010, rd_src=0, alu_src2=0, one writeenable pulse 3 cycles after ack, retired=1.
REQ-037 Sequence ADDI, ANDI, ORI, XORI with immediate ack, run held 1 -> alu_op 010,100,101,111, rd_src=1, alu_src2=1 each, retired=4, 4 cycles per instruction.
REQ-038 opcode 6'h2a, or opcode 6'h00 with funct 6'h21 -> except=1 two cycles after ack, no writeenable, retired unchanged; run toggling does not clear except; reset clears it.
REQ-039 Reset asserted between clock edges while in FETCH with imem_req=1 -> imem_req, busy and all outputs 0 before the next edge; IDLE after release.
REQ-040 Preload retired to 16'hFFFF (run 65535 instructions), retire one more -> retired=16'h0000, normal operation continues.
REQ-041 run dropped during EXECUTE -> WRITEBACK still pulses writeenable/pc_en once, then IDLE with busy=0 and imem_req=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM (fetch/decode/execute/writeback)
//
// Purpose: sequences one instruction at a time through FETCH, DECODE, EXECUTE
// and WRITEBACK. It decodes a small ALU subset of MIPS, drives datapath
// control, and parks in EXCEPT on any unsupported instruction until reset.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high; forces IDLE and clears all outputs
//   run          in   level; 1 = keep issuing instructions
//   imem_ack     in   instruction word valid (only looked at in FETCH)
//   imem_data    in   [31:0] instruction word, opcode [31:26], funct [5:0]
//   imem_req     out  fetch request, high for every FETCH cycle
//   pc_en        out  one-cycle PC advance strobe (WRITEBACK)
//   alu_op       out  [2:0] registered ALU operation select
//   rd_src       out  1 = destination is rt (I-type), 0 = rd (R-type)
//   alu_src2     out  1 = ALU operand B is the extended immediate
//   writeenable  out  register-file write strobe (WRITEBACK)
//   except       out  sticky illegal-instruction flag
//   busy         out  1 in any state other than IDLE and EXCEPT
//   retired      out  [15:0] completed-instruction count, wraps silently

module mips_multicycle_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        imem_req,
  output logic        pc_en,
  output logic [2:0]  alu_op,
  output logic        rd_src,
  output logic        alu_src2,
  output logic        writeenable,
  output logic        except,
  output logic        busy,
  output logic [15:0] retired
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_EXCEPT    = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  logic [2:0]  state;
  logic [2:0]  next_state;

  // Only the opcode and funct fields steer control; the register and
  // immediate fields are consumed by the datapath, not by this block.
  logic [5:0]  ir_opcode;
  logic [5:0]  ir_funct;
  logic        unused_imem_fields;

  logic        dec_legal;
  logic [2:0]  dec_alu_op;
  logic        dec_rd_src;
  logic        dec_alu_src2;

  logic [2:0]  alu_op_q;
  logic        rd_src_q;
  logic        alu_src2_q;
  logic [15:0] retired_cnt;

  assign unused_imem_fields = ^imem_data[25:6];

  // Instruction classification from the captured IR fields.
  always_comb begin
    dec_legal    = 1'b0;
    dec_alu_op   = ALU_ADD;
    dec_rd_src   = 1'b0;
    dec_alu_src2 = 1'b0;
    case (ir_opcode)
      OP_RTYPE: begin
        dec_legal = 1'b1;
        case (ir_funct)
          FN_ADD:  dec_alu_op = ALU_ADD;
          FN_SUB:  dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          FN_XOR:  dec_alu_op = ALU_XOR;
          FN_NOR:  dec_alu_op = ALU_NOR;
          default: dec_legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_legal    = 1'b1;
        dec_alu_op   = ALU_ADD;
        dec_rd_src   = 1'b1;
        dec_alu_src2 = 1'b1;
      end
      OP_ANDI: begin
        dec_legal    = 1'b1;
        dec_alu_op   = ALU_AND;
        dec_rd_src   = 1'b1;
        dec_alu_src2 = 1'b1;
      end
      OP_ORI: begin
        dec_legal    = 1'b1;
        dec_alu_op   = ALU_OR;
        dec_rd_src   = 1'b1;
        dec_alu_src2 = 1'b1;
      end
      OP_XORI: begin
        dec_legal    = 1'b1;
        dec_alu_op   = ALU_XOR;
        dec_rd_src   = 1'b1;
        dec_alu_src2 = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (run) next_state = S_FETCH;
      S_FETCH:     if (imem_ack) next_state = S_DECODE;
      S_DECODE:    next_state = dec_legal ? S_EXECUTE : S_EXCEPT;
      S_EXECUTE:   next_state = S_WRITEBACK;
      // run is only consulted here, so dropping it mid-instruction
      // still lets the current instruction retire.
      S_WRITEBACK: next_state = run ? S_FETCH : S_IDLE;
      S_EXCEPT:    next_state = S_EXCEPT;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_opcode <= 6'h00;
      ir_funct  <= 6'h00;
    end else if (state == S_FETCH && imem_ack) begin
      ir_opcode <= imem_data[31:26];
      ir_funct  <= imem_data[5:0];
    end
  end

  // Control fields load on the DECODE->EXECUTE edge and then hold until
  // the next legal decode, so they are stable through EXECUTE/WRITEBACK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_op_q   <= 3'b000;
      rd_src_q   <= 1'b0;
      alu_src2_q <= 1'b0;
    end else if (state == S_DECODE && dec_legal) begin
      alu_op_q   <= dec_alu_op;
      rd_src_q   <= dec_rd_src;
      alu_src2_q <= dec_alu_src2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_cnt <= 16'h0000;
    end else if (state == S_WRITEBACK) begin
      retired_cnt <= retired_cnt + 16'h0001;
    end
  end

  // All strobes decode straight from the state register, so an async
  // reset clears them in the same instant it clears the state.
  assign imem_req    = (state == S_FETCH);
  assign writeenable = (state == S_WRITEBACK);
  assign pc_en       = (state == S_WRITEBACK);
  assign except      = (state == S_EXCEPT);
  assign busy        = (state != S_IDLE) && (state != S_EXCEPT);
  assign alu_op      = alu_op_q;
  assign rd_src      = rd_src_q;
  assign alu_src2    = alu_src2_q;
  assign retired     = retired_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        imem_req;
  logic        pc_en;
  logic [2:0]  alu_op;
  logic        rd_src;
  logic        alu_src2;
  logic        writeenable;
  logic        except;
  logic        busy;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  mips_multicycle_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .pc_en       (pc_en),
    .alu_op      (alu_op),
    .rd_src      (rd_src),
    .alu_src2    (alu_src2),
    .writeenable (writeenable),
    .except      (except),
    .busy        (busy),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        legal;
    logic [2:0]  op;
    logic        rd;
    logic        src2;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [25:0] all_outs();
    return {imem_req, pc_en, writeenable, except, busy, rd_src, alu_src2, alu_op, retired};
  endfunction

  task automatic do_reset();
    run = 1'b0;
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("reset outputs", {6'h0, all_outs()}, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  // Starts in FETCH with run=1; acks immediately and ends in the next FETCH.
  task automatic run_instr(input logic [31:0] instr);
    imem_ack = 1'b1;
    imem_data = instr;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{"ADD",   32'h00221820, 1'b1, 3'b010, 1'b0, 1'b0};
    vecs[1]  = '{"SUB",   32'h00221822, 1'b1, 3'b011, 1'b0, 1'b0};
    vecs[2]  = '{"AND",   32'h00221824, 1'b1, 3'b100, 1'b0, 1'b0};
    vecs[3]  = '{"OR",    32'h00221825, 1'b1, 3'b101, 1'b0, 1'b0};
    vecs[4]  = '{"XOR",   32'h00221826, 1'b1, 3'b111, 1'b0, 1'b0};
    vecs[5]  = '{"NOR",   32'h00221827, 1'b1, 3'b110, 1'b0, 1'b0};
    vecs[6]  = '{"ADDI",  32'h20220005, 1'b1, 3'b010, 1'b1, 1'b1};
    vecs[7]  = '{"ANDI",  32'h3022000f, 1'b1, 3'b100, 1'b1, 1'b1};
    vecs[8]  = '{"ORI",   32'h342200f0, 1'b1, 3'b101, 1'b1, 1'b1};
    vecs[9]  = '{"XORI",  32'h3822ffff, 1'b1, 3'b111, 1'b1, 1'b1};
    vecs[10] = '{"OP2A",  32'ha8000000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{"FN21",  32'h00221821, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[12] = '{"LW",    32'h8c220000, 1'b0, 3'b000, 1'b0, 1'b0};

    // Idle after reset release: no fetch without run.
    do_reset();
    tick();
    tick();
    check("idle no req", {31'h0, imem_req}, 32'h0);
    check("idle busy", {31'h0, busy}, 32'h0);

    // Table: one instruction per vector from a fresh reset.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      run = 1'b1;
      tick();
      check({vecs[i].name, " fetch req"}, {30'h0, imem_req, busy}, 32'h3);
      imem_ack = 1'b1;
      imem_data = vecs[i].instr;
      tick();
      // ack with junk outside FETCH must be ignored
      imem_data = 32'hffffffff;
      check({vecs[i].name, " decode"}, {29'h0, imem_req, writeenable, busy}, 32'h1);
      tick();
      imem_ack = 1'b0;
      if (vecs[i].legal) begin
        check({vecs[i].name, " ctrl"}, {27'h0, alu_op, rd_src, alu_src2},
              {27'h0, vecs[i].op, vecs[i].rd, vecs[i].src2});
        check({vecs[i].name, " exec we"}, {30'h0, writeenable, pc_en}, 32'h0);
        tick();
        check({vecs[i].name, " wb strobes"}, {30'h0, writeenable, pc_en}, 32'h3);
        run = 1'b0;
        tick();
        check({vecs[i].name, " post wb"}, {28'h0, writeenable, pc_en, busy, imem_req}, 32'h0);
        check({vecs[i].name, " retired"}, {16'h0, retired}, 32'h1);
        check({vecs[i].name, " ctrl held"}, {27'h0, alu_op, rd_src, alu_src2},
              {27'h0, vecs[i].op, vecs[i].rd, vecs[i].src2});
      end else begin
        check({vecs[i].name, " except"}, {28'h0, except, busy, imem_req, writeenable}, 32'h8);
        tick();
        check({vecs[i].name, " except wb"}, {29'h0, except, writeenable, pc_en}, 32'h4);
        check({vecs[i].name, " retired"}, {16'h0, retired}, 32'h0);
      end
    end

    // Delayed ack: req held for two cycles, one writeenable pulse 3 cycles after ack.
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("slow ack req1", {31'h0, imem_req}, 32'h1);
    tick();
    check("slow ack req2", {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1;
    imem_data = 32'h00221820;
    tick();
    imem_ack = 1'b0;
    check("slow we c1", {31'h0, writeenable}, 32'h0);
    tick();
    check("slow we c2", {31'h0, writeenable}, 32'h0);
    tick();
    check("slow we c3", {30'h0, writeenable, pc_en}, 32'h3);
    check("slow ctrl", {27'h0, alu_op, rd_src, alu_src2}, {27'h0, 3'b010, 1'b0, 1'b0});
    tick();
    check("slow we c4", {31'h0, writeenable}, 32'h0);
    check("slow req again", {31'h0, imem_req}, 32'h1);
    check("slow retired", {16'h0, retired}, 32'h1);

    // Back-to-back I-type, 4 cycles each.
    do_reset();
    run = 1'b1;
    tick();
    begin
      logic [31:0] seq_i[4];
      logic [2:0]  seq_op[4];
      seq_i[0] = 32'h20220005; seq_op[0] = 3'b010;
      seq_i[1] = 32'h3022000f; seq_op[1] = 3'b100;
      seq_i[2] = 32'h342200f0; seq_op[2] = 3'b101;
      seq_i[3] = 32'h3822ffff; seq_op[3] = 3'b111;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b2b%0d req", k), {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        imem_data = seq_i[k];
        tick();
        imem_ack = 1'b0;
        tick();
        check($sformatf("b2b%0d ctrl", k), {27'h0, alu_op, rd_src, alu_src2},
              {27'h0, seq_op[k], 1'b1, 1'b1});
        tick();
        check($sformatf("b2b%0d we", k), {31'h0, writeenable}, 32'h1);
        tick();
      end
    end
    check("b2b retired", {16'h0, retired}, 32'h4);

    // Except is sticky against run and ack, cleared by reset.
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1;
    imem_data = 32'ha8000000;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      run = k[0];
      imem_ack = ~k[0];
      tick();
      check($sformatf("sticky%0d", k), {27'h0, except, busy, imem_req, writeenable, pc_en}, 32'h10);
    end
    check("sticky retired", {16'h0, retired}, 32'h0);
    imem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("except cleared", {6'h0, all_outs()}, 32'h0);
    tick();
    reset = 1'b0;

    // Async reset mid-FETCH, before the next edge.
    run = 1'b1;
    tick();
    check("pre-reset req", {31'h0, imem_req}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("async reset outs", {6'h0, all_outs()}, 32'h0);
    #3;
    reset = 1'b0;
    run = 1'b0;
    tick();
    check("after release idle", {30'h0, busy, imem_req}, 32'h0);
    run = 1'b1;
    tick();
    check("after release fetch", {30'h0, busy, imem_req}, 32'h3);

    // run dropped in EXECUTE: instruction completes, then IDLE.
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1;
    imem_data = 32'h00221822;
    tick();
    imem_ack = 1'b0;
    tick();
    run = 1'b0;
    tick();
    check("drop run wb", {30'h0, writeenable, pc_en}, 32'h3);
    tick();
    check("drop run idle", {28'h0, writeenable, pc_en, busy, imem_req}, 32'h0);
    tick();
    check("drop run stay", {30'h0, busy, imem_req}, 32'h0);
    check("drop run retired", {16'h0, retired}, 32'h1);

    // Retired wrap: preload the counter, then retire two more.
    do_reset();
    force dut.retired_cnt = 16'hffff;
    tick();
    release dut.retired_cnt;
    #1;
    check("preload", {16'h0, retired}, 32'h0000ffff);
    run = 1'b1;
    tick();
    run_instr(32'h00221824);
    check("wrap", {16'h0, retired}, 32'h0);
    run_instr(32'h3822ffff);
    check("after wrap", {16'h0, retired}, 32'h1);
    check("after wrap run", {30'h0, busy, imem_req}, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
